// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame config and received-byte status for uart_rx
//   master: drives i_rx/i_parity_en/i_even_parity, observes receiver outputs
//   slave : the receiver; consumes the line and config, drives o_* status
interface uart_rx_if;
   logic       i_rx;
   logic       i_parity_en;
   logic       i_even_parity;
   logic [7:0] o_data_out;
   logic       o_rx_valid;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_rx_busy;
   modport master (
      output i_rx, i_parity_en, i_even_parity,
      input  o_data_out, o_rx_valid, o_parity_err, o_frame_err, o_rx_busy
   );
   modport slave (
      input  i_rx, i_parity_en, i_even_parity,
      output o_data_out, o_rx_valid, o_parity_err, o_frame_err, o_rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 / 8E1 / 8O1 frames, LSB first
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_if.slave
//     i_rx          serial line, idle high, asynchronous to clk
//     i_parity_en   frame carries a parity bit after D7
//     i_even_parity 1 = even parity, 0 = odd
//     o_data_out    last received byte, held until next o_rx_valid
//     o_rx_valid    one-cycle pulse when data/error flags update
//     o_parity_err  parity mismatch on last frame
//     o_frame_err   stop bit sampled low on last frame
//     o_rx_busy     receiver is inside a frame
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic     clk,
   input logic     rst_n,
   uart_rx_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   logic          r_sync1, r_sync2, r_prev;
   logic [1:0]    r_flush;
   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_cfg_pen, r_cfg_even, r_perr;
   logic [7:0]    r_data;
   logic          r_valid, r_perr_out, r_ferr_out;
   logic          w_rx_s, w_fall, w_centre;
   assign w_rx_s   = r_sync2;
   assign w_fall   = r_prev & ~w_rx_s;
   assign w_centre = r_cnt == FULL;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_prev     <= 1'b0;
         r_flush    <= 2'b00;
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_cfg_pen  <= 1'b0;
         r_cfg_even <= 1'b0;
         r_perr     <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_perr_out <= 1'b0;
         r_ferr_out <= 1'b0;
      end else begin
         r_sync1 <= bus.i_rx;
         r_sync2 <= r_sync1;
         // The synchroniser's reset value is not a real line level; only arm edge
         // detection once it has been flushed, so a line already low after reset
         // is not mistaken for a start bit.
         r_flush <= {r_flush[0], 1'b1};
         r_prev  <= w_rx_s & r_flush[1];
         r_valid <= 1'b0;
         r_cnt   <= r_cnt + CW'(1);
         case (r_state)
            IDLE: if (w_fall) begin
               r_state    <= START;
               r_cnt      <= '0;
               r_perr     <= 1'b0;
               r_cfg_pen  <= bus.i_parity_en;
               r_cfg_even <= bus.i_even_parity;
            end
            START: if (r_cnt == HALF) begin
               r_state <= w_rx_s ? IDLE : DATA;
               r_cnt   <= '0;
               r_bit   <= '0;
            end
            DATA: if (w_centre) begin
               r_cnt   <= '0;
               r_shift <= {w_rx_s, r_shift[7:1]};
               r_bit   <= r_bit + 3'd1;
               if (r_bit == 3'd7) r_state <= r_cfg_pen ? PARITY : STOP;
            end
            PARITY: if (w_centre) begin
               r_cnt   <= '0;
               r_perr  <= (^{r_shift, w_rx_s}) ^ ~r_cfg_even;
               r_state <= STOP;
            end
            STOP: if (w_centre) begin
               // Returning to IDLE at the stop-bit centre leaves half a bit to
               // catch a back-to-back start edge.
               r_cnt      <= '0;
               r_data     <= r_shift;
               r_perr_out <= r_cfg_pen & r_perr;
               r_ferr_out <= ~w_rx_s;
               r_valid    <= 1'b1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.o_data_out   = r_data;
   assign bus.o_rx_valid   = r_valid;
   assign bus.o_parity_err = r_perr_out;
   assign bus.o_frame_err  = r_ferr_out;
   assign bus.o_rx_busy    = r_state != IDLE;
endmodule
